// File: rtl/rr_grant_encoder_4.sv
// Four-requester round-robin arbiter. The registered grant leaves as an encoded
// index plus enable so it can drive a 2x4 decoder directly.
module rr_grant_encoder_4 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       gnt_x1,
  output logic       gnt_x2,
  output logic       gnt_en,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  localparam bit                TIMER_ON  = (MAX_HOLD != 0);

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              gnt_en_q, gnt_en_d;
  logic [1:0]        gnt_idx_q, gnt_idx_d;
  logic              timeout_q, timeout_d;

  // Candidate k is the requester k places after the pointer.
  logic [1:0] cand [4];
  logic [3:0] hit;
  logic [1:0] pick_idx;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
      assign cand[gi] = ptr_q + 2'(gi);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    pick_idx = cand[0];
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) pick_idx = cand[k];
    end
  end

  logic still_req;
  logic expired;
  assign still_req = req[idx_q];
  assign expired   = TIMER_ON && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    gnt_en_d   = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d    = S_GRANT;
          idx_d      = pick_idx;
          hold_cnt_d = '0;
          gnt_en_d   = 1'b1;
        end
      end
      S_GRANT: begin
        gnt_en_d   = 1'b1;
        hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
        // Release, withdrawal and expiry all end the grant; only a pure expiry pulses timeout.
        if (done || !still_req || expired) begin
          state_d   = S_GAP;
          gnt_en_d  = 1'b0;
          ptr_d     = idx_q + 2'd1;
          timeout_d = !done && still_req && expired;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt_idx_d = gnt_en_d ? idx_d : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd0;
      idx_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_en_q   <= 1'b0;
      gnt_idx_q  <= 2'b00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_en_q   <= gnt_en_d;
      gnt_idx_q  <= gnt_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_en  = gnt_en_q;
  assign gnt_x2  = gnt_idx_q[1];
  assign gnt_x1  = gnt_idx_q[0];
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_encoder_4.sv
// Directed bench for rr_grant_encoder_4 (MAX_HOLD=4); every cycle's outputs are
// compared with hand-derived values and with the downstream decoder view.
module tb_rr_grant_encoder_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       gnt_x1, gnt_x2, gnt_en, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_grant_encoder_4 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt_x1  (gnt_x1),
    .gnt_x2  (gnt_x2),
    .gnt_en  (gnt_en),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit en, input logic [1:0] idx, input bit to);
    logic [3:0] y_got, y_exp;
    logic [1:0] idx_exp;
    idx_exp = en ? idx : 2'b00;
    y_got   = gnt_en ? (4'b0001 << {gnt_x2, gnt_x1}) : 4'b0000;
    y_exp   = en ? (4'b0001 << idx) : 4'b0000;
    check({tag, ".en"}, {7'd0, gnt_en}, {7'd0, en});
    check({tag, ".idx"}, {6'd0, gnt_x2, gnt_x1}, {6'd0, idx_exp});
    check({tag, ".to"}, {7'd0, timeout}, {7'd0, to});
    check({tag, ".y"}, {4'd0, y_got}, {4'd0, y_exp});
    $display("[TB] %-10s en=%0b idx=%0d to=%0b y=%b", tag, gnt_en, {gnt_x2, gnt_x1}, timeout, y_got);
  endtask

  initial begin
    logic [1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    rst = 1'b1; req = 4'b0000; done = 1'b0;
    cyc(); expect_out("reset", 1'b0, 2'd0, 1'b0);

    // 1: single requester 2, released after 3 cycles; then ptr=3 picks 3 from 1001
    rst = 1'b0; req = 4'b0100;
    cyc(); expect_out("t1.g0", 1'b1, 2'd2, 1'b0);
    cyc(); expect_out("t1.g1", 1'b1, 2'd2, 1'b0);
    cyc(); expect_out("t1.g2", 1'b1, 2'd2, 1'b0);
    done = 1'b1;
    cyc(); expect_out("t1.gap", 1'b0, 2'd0, 1'b0);
    done = 1'b0; req = 4'b1001;
    cyc(); expect_out("t1.idle", 1'b0, 2'd0, 1'b0);
    cyc(); expect_out("t1.ptr3", 1'b1, 2'd3, 1'b0);
    done = 1'b1;
    cyc(); expect_out("t1.gap2", 1'b0, 2'd0, 1'b0);
    done = 1'b0; req = 4'b0000;
    cyc(); expect_out("t1.idle2", 1'b0, 2'd0, 1'b0);
    cyc(); expect_out("t1.idle3", 1'b0, 2'd0, 1'b0);

    // 2: all requesting, done every grant cycle -> 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc(); expect_out($sformatf("t2.g%0d", k), 1'b1, order[k], 1'b0);
      done = 1'b1;
      cyc(); expect_out($sformatf("t2.gap%0d", k), 1'b0, 2'd0, 1'b0);
      done = 1'b0;
      cyc(); expect_out($sformatf("t2.idl%0d", k), 1'b0, 2'd0, 1'b0);
    end
    req = 4'b0000;
    cyc(); expect_out("t2.end", 1'b0, 2'd0, 1'b0);

    // 3: hold timeout after 4 cycles, then regrant to 0 (ptr=1 wraps round)
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      cyc(); expect_out($sformatf("t3.h%0d", k), 1'b1, 2'd0, 1'b0);
    end
    cyc(); expect_out("t3.tmo", 1'b0, 2'd0, 1'b1);
    cyc(); expect_out("t3.idle", 1'b0, 2'd0, 1'b0);
    cyc(); expect_out("t3.regnt", 1'b1, 2'd0, 1'b0);
    done = 1'b1;
    cyc(); expect_out("t3.gap", 1'b0, 2'd0, 1'b0);
    done = 1'b0; req = 4'b0000;
    cyc(); expect_out("t3.idle2", 1'b0, 2'd0, 1'b0);

    // 4: grant 2, other bits wiggle, then req[2] drops; 1001 then goes to 3
    req = 4'b0100;
    cyc(); expect_out("t4.g2", 1'b1, 2'd2, 1'b0);
    req = 4'b1110;
    cyc(); expect_out("t4.hold", 1'b1, 2'd2, 1'b0);
    req = 4'b1011;
    cyc(); expect_out("t4.drop", 1'b0, 2'd0, 1'b0);
    req = 4'b1001;
    cyc(); expect_out("t4.idle", 1'b0, 2'd0, 1'b0);
    cyc(); expect_out("t4.g3", 1'b1, 2'd3, 1'b0);
    done = 1'b1;
    cyc(); expect_out("t4.gap", 1'b0, 2'd0, 1'b0);
    done = 1'b0; req = 4'b0000;
    cyc(); expect_out("t4.idle2", 1'b0, 2'd0, 1'b0);

    // 5: done coincides with expiry -> no timeout
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      cyc(); expect_out($sformatf("t5.h%0d", k), 1'b1, 2'd0, 1'b0);
    end
    done = 1'b1;
    cyc(); expect_out("t5.rel", 1'b0, 2'd0, 1'b0);
    done = 1'b0; req = 4'b0000;
    cyc(); expect_out("t5.idle", 1'b0, 2'd0, 1'b0);

    // 6: move ptr to 2, reset mid-grant at expiry, then ptr restarts at 0
    req = 4'b0010;
    cyc(); expect_out("t6.pre", 1'b1, 2'd1, 1'b0);
    done = 1'b1;
    cyc(); expect_out("t6.pgap", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    cyc(); expect_out("t6.pidle", 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(); expect_out($sformatf("t6.h%0d", k), 1'b1, 2'd1, 1'b0);
    end
    rst = 1'b1;
    cyc(); expect_out("t6.rst", 1'b0, 2'd0, 1'b0);
    req = 4'b1010;
    cyc(); expect_out("t6.rst2", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    cyc(); expect_out("t6.g1", 1'b1, 2'd1, 1'b0);
    done = 1'b1;
    cyc(); expect_out("t6.gap", 1'b0, 2'd0, 1'b0);
    done = 1'b0; req = 4'b0000;
    cyc(); expect_out("t6.idle", 1'b0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
